// File: rtl/lcd_write_ctrl.sv
// HD44780 8-bit parallel write controller: autonomous power-up init, then one
// byte per valid/ready handshake with hardware-timed enable pulse and execution wait.
module lcd_write_ctrl #(
  parameter int SETUP_CYC      = 2,
  parameter int EN_HIGH_CYC    = 25,
  parameter int HOLD_CYC       = 2,
  parameter int SHORT_WAIT_CYC = 2000,
  parameter int LONG_WAIT_CYC  = 80000,
  parameter int POWERUP_CYC    = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       init_done,
  output logic       busy,
  output logic       lcd_bl,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CYC = max2(max2(max2(SETUP_CYC, EN_HIGH_CYC), max2(HOLD_CYC, SHORT_WAIT_CYC)),
                                max2(LONG_WAIT_CYC, POWERUP_CYC));
  localparam int CW = $clog2(MAX_CYC + 1);

  // The ROM load happens on the edge leaving POWERUP/WAIT, so INIT_LOAD never dwells.
  typedef enum logic [2:0] {POWERUP, SETUP, PULSE, HOLD, WAIT, IDLE} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n, wait_last;
  logic [2:0]    idx, idx_n;
  logic          long_wait, long_n;
  logic          en_n, rs_n, ready_n, done_n, load_init;
  logic [7:0]    db_n;

  function automatic logic [7:0] init_rom(input logic [2:0] i);
    case (i)
      3'd0, 3'd1, 3'd2: return 8'h30;
      3'd3:             return 8'h38;
      3'd4:             return 8'h08;
      3'd5:             return 8'h01;
      3'd6:             return 8'h06;
      default:          return 8'h0C;
    endcase
  endfunction

  // Clear (0x01) and home (0x02/0x03) need the long execution time.
  function automatic logic is_long(input logic rs, input logic [7:0] d);
    return !rs && (d[7:2] == 6'd0) && (d != 8'd0);
  endfunction

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + CW'(1);
    idx_n     = idx;
    long_n    = long_wait;
    en_n      = lcd_en;
    rs_n      = lcd_rs;
    db_n      = lcd_db;
    ready_n   = cmd_ready;
    done_n    = init_done;
    load_init = 1'b0;
    wait_last = long_wait ? CW'(LONG_WAIT_CYC - 1) : CW'(SHORT_WAIT_CYC - 1);
    case (state)
      POWERUP: if (cnt == CW'(POWERUP_CYC - 1)) load_init = 1'b1;
      SETUP: if (cnt == CW'(SETUP_CYC - 1)) begin
        state_n = PULSE;
        cnt_n   = '0;
        en_n    = 1'b1;
      end
      PULSE: if (cnt == CW'(EN_HIGH_CYC - 1)) begin
        state_n = HOLD;
        cnt_n   = '0;
        en_n    = 1'b0;
      end
      HOLD: if (cnt == CW'(HOLD_CYC - 1)) begin
        state_n = WAIT;
        cnt_n   = '0;
      end
      WAIT: begin
        if (!init_done && idx != 3'd7) begin
          if (cnt == wait_last) begin
            idx_n     = idx + 3'd1;
            load_init = 1'b1;
          end
        // Leaving one cycle early: the first IDLE cycle is the last wait cycle,
        // so the next accept edge lands exactly at the end of the wait.
        end else if (cnt == wait_last - CW'(1)) begin
          state_n = IDLE;
          cnt_n   = '0;
          ready_n = 1'b1;
          done_n  = 1'b1;
        end
      end
      IDLE: begin
        cnt_n = '0;
        if (cmd_valid && cmd_ready) begin
          state_n = SETUP;
          rs_n    = cmd_rs;
          db_n    = cmd_data;
          long_n  = is_long(cmd_rs, cmd_data);
          ready_n = 1'b0;
        end
      end
      default: begin
        state_n = POWERUP;
        cnt_n   = '0;
      end
    endcase
    if (load_init) begin
      state_n = SETUP;
      cnt_n   = '0;
      rs_n    = 1'b0;
      db_n    = init_rom(idx_n);
      long_n  = (idx_n == 3'd0) || is_long(1'b0, init_rom(idx_n));
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= POWERUP;
      cnt       <= '0;
      idx       <= 3'd0;
      long_wait <= 1'b0;
      lcd_en    <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_db    <= 8'h00;
      cmd_ready <= 1'b0;
      busy      <= 1'b1;
      init_done <= 1'b0;
      lcd_bl    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      idx       <= idx_n;
      long_wait <= long_n;
      lcd_en    <= en_n;
      lcd_rs    <= rs_n;
      lcd_db    <= db_n;
      cmd_ready <= ready_n;
      busy      <= !ready_n;
      init_done <= done_n;
      lcd_bl    <= done_n;
    end
  end

  assign lcd_rw = 1'b0;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Bench for lcd_write_ctrl: a write-timeline model checked every cycle, plus
// directed scenarios with hand-computed edge offsets.
module tb_lcd_write_ctrl;

  localparam int SU = 2, EH = 4, HO = 2, SHORT_C = 10, LONG_C = 50, PU_C = 100;

  logic       clock, reset, cmd_valid, cmd_rs;
  logic [7:0] cmd_data;
  logic       cmd_ready, init_done, busy, lcd_bl, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_db;

  lcd_write_ctrl #(
    .SETUP_CYC(SU), .EN_HIGH_CYC(EH), .HOLD_CYC(HO),
    .SHORT_WAIT_CYC(SHORT_C), .LONG_WAIT_CYC(LONG_C), .POWERUP_CYC(PU_C)
  ) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_rs(cmd_rs), .cmd_data(cmd_data), .init_done(init_done), .busy(busy),
    .lcd_bl(lcd_bl), .lcd_en(lcd_en), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_db(lcd_db)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int n_chk = 0, n_fail = 0;
  int ec = 0;
  logic [7:0] rom_exp [8] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};
  logic [7:0] cap_db [8];

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Edge number since reset release (first non-reset edge is 1).
  always @(posedge clock) ec = reset ? 0 : ec + 1;

  // Model: each write is a timeline of SU+EH+HO+wait cycles from its load edge.
  localparam int M_PU = 0, M_WR = 1, M_IDLE = 2;
  int m_mode = M_PU, m_cnt = 0, m_idx = 0, m_wait = 0;
  logic m_init = 1'b1, m_done = 1'b0, m_rs = 1'b0, started = 1'b0;
  logic [7:0] m_db = 8'h00;

  function automatic int wait_of(input logic r, input logic [7:0] d);
    return (!r && d >= 8'h01 && d <= 8'h03) ? LONG_C : SHORT_C;
  endfunction

  task automatic m_start(input logic r, input logic [7:0] d, input int w);
    m_mode = M_WR; m_cnt = 0; m_rs = r; m_db = d; m_wait = w;
  endtask

  always @(posedge clock) begin
    started = 1'b1;
    if (reset) begin
      m_mode = M_PU; m_cnt = 0; m_idx = 0; m_init = 1'b1; m_done = 1'b0;
      m_rs = 1'b0; m_db = 8'h00; m_wait = 0;
    end else begin
      case (m_mode)
        M_PU: begin
          m_cnt++;
          if (m_cnt == PU_C) m_start(1'b0, rom_exp[0], LONG_C);
        end
        M_WR: begin
          m_cnt++;
          if (m_init && m_idx < 7) begin
            if (m_cnt == SU + EH + HO + m_wait) begin
              m_idx++;
              m_start(1'b0, rom_exp[m_idx], wait_of(1'b0, rom_exp[m_idx]));
            end
          end else if (m_cnt == SU + EH + HO + m_wait - 1) begin
            m_mode = M_IDLE;
            if (m_init) begin m_done = 1'b1; m_init = 1'b0; end
          end
        end
        default: if (cmd_valid) m_start(cmd_rs, cmd_data, wait_of(cmd_rs, cmd_data));
      endcase
    end
  end

  always @(negedge clock) begin
    if (started) begin
      check("en",    lcd_en,    (m_mode == M_WR && m_cnt >= SU && m_cnt < SU + EH) ? 1 : 0);
      check("ready", cmd_ready, (m_mode == M_IDLE) ? 1 : 0);
      check("busy",  busy,      (m_mode == M_IDLE) ? 0 : 1);
      check("done",  init_done, m_done);
      check("bl",    lcd_bl,    m_done);
      check("rw",    lcd_rw,    0);
      check("rs",    lcd_rs,    m_rs);
      check("db",    lcd_db,    m_db);
    end
  end

  task automatic wait_ready(input int n);
    bit ok = 0;
    for (int i = 0; i < n; i++) begin
      if (cmd_ready) begin ok = 1; break; end
      @(negedge clock);
    end
    if (!ok) check("ready_timeout", 0, 1);
  endtask

  // Returns at the negedge where init_done is first seen; done_edge is the
  // first edge that samples it high.
  task automatic run_init(output int done_edge, output int npulse, output int bad_w,
                          output int early, output int rs_hi);
    int w = 0;
    logic pen = 1'b0;
    done_edge = -1; npulse = 0; bad_w = 0; early = 0; rs_hi = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clock);
      if (lcd_en && !pen) begin
        if (npulse < 8) cap_db[npulse] = lcd_db;
        if (lcd_rs) rs_hi++;
        npulse++; w = 0;
      end
      if (lcd_en) w++;
      if (!lcd_en && pen && w != EH) bad_w++;
      if (cmd_ready && !init_done) early++;
      pen = lcd_en;
      if (init_done) begin done_edge = ec + 1; break; end
    end
  endtask

  task automatic send(input logic r, input logic [7:0] d,
                      output int e0, output int en_r, output int en_f, output int rdy);
    wait_ready(200);
    cmd_valid = 1'b1; cmd_rs = r; cmd_data = d;
    @(negedge clock);
    cmd_valid = 1'b0; e0 = ec;
    check("acc_rs", lcd_rs, r);
    check("acc_db", lcd_db, d);
    en_r = -1; en_f = -1; rdy = -1;
    for (int i = 0; i < 200; i++) begin
      if (lcd_en && en_r < 0) en_r = ec;
      if (!lcd_en && en_r >= 0 && en_f < 0) en_f = ec;
      if (cmd_ready) begin rdy = ec + 1; break; end
      @(negedge clock);
    end
    if (rdy < 0) check("send_timeout", 0, 1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int de, np, bw, ea, rh, e0, er, ef, rd;
    int acc[$];
    logic pr, prs;
    logic [7:0] pd;
    reset = 1'b1; cmd_valid = 1'b0; cmd_rs = 1'b0; cmd_data = 8'h00;
    repeat (3) @(negedge clock);
    check("rst_en", lcd_en, 0);
    check("rst_ready", cmd_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_done", init_done, 0);
    check("rst_db", lcd_db, 8'h00);
    // Byte offered during power-up/init must wait for the first IDLE edge.
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h55;
    reset = 1'b0;

    run_init(de, np, bw, ea, rh);
    check("init_pulses", np, 8);
    check("init_width", bw, 0);
    check("init_early_ready", ea, 0);
    check("init_rs", rh, 0);
    for (int i = 0; i < 8; i++) check("init_db", cap_db[i], rom_exp[i]);
    check("init_done_edge", de, 324);
    @(negedge clock);
    cmd_valid = 1'b0;
    check("pend_acc_edge", ec, 324);
    check("pend_db", lcd_db, 8'h55);
    check("pend_rs", lcd_rs, 1);

    send(1'b1, 8'h41, e0, er, ef, rd);
    check("d41_en_rise", er - e0, 2);
    check("d41_en_fall", ef - e0, 6);
    check("d41_ready", rd - e0, 18);

    send(1'b0, 8'h01, e0, er, ef, rd);
    check("clr_ready", rd - e0, 58);
    send(1'b1, 8'h01, e0, er, ef, rd);
    check("data01_ready", rd - e0, 18);
    send(1'b0, 8'h02, e0, er, ef, rd);
    check("home_ready", rd - e0, 58);
    send(1'b0, 8'h04, e0, er, ef, rd);
    check("entry_ready", rd - e0, 18);

    // Valid held high with data changing every cycle.
    wait_ready(200);
    cmd_valid = 1'b1;
    for (int i = 0; i < 80 && acc.size() < 3; i++) begin
      cmd_data = 8'h60 + 8'(i); cmd_rs = i[0];
      pr = cmd_ready; pd = cmd_data; prs = cmd_rs;
      @(negedge clock);
      if (pr) begin
        acc.push_back(ec);
        check("burst_db", lcd_db, pd);
        check("burst_rs", lcd_rs, prs);
      end
    end
    cmd_valid = 1'b0;
    check("burst_n", acc.size(), 3);
    if (acc.size() == 3) begin
      check("burst_gap0", acc[1] - acc[0], 18);
      check("burst_gap1", acc[2] - acc[1], 18);
    end

    // One-cycle reset while lcd_en is high.
    wait_ready(200);
    cmd_valid = 1'b1; cmd_rs = 1'b1; cmd_data = 8'h7E;
    @(negedge clock);
    cmd_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (lcd_en) break;
      @(negedge clock);
    end
    check("abort_en_seen", lcd_en, 1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("abort_en", lcd_en, 0);
    check("abort_done", init_done, 0);
    check("abort_bl", lcd_bl, 0);
    check("abort_db", lcd_db, 8'h00);
    run_init(de, np, bw, ea, rh);
    check("reinit_pulses", np, 8);
    check("reinit_done_edge", de, 324);
    repeat (3) @(negedge clock);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
